// File: rtl/mult_shift_add.sv
// rtl/mult_shift_add.sv - sequential unsigned shift-and-add multiplier
module mult_shift_add #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    output logic [2*N-1:0]   product,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_TEST  = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [N:0]      a_q, a_d;
    logic [N-1:0]    q_q, q_d;
    logic [N-1:0]    m_q, m_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  product_q, product_d;
    logic [2*N:0]    shifted;

    // {A,Q} shifted right by one with a zero entering the carry bit
    assign shifted = {1'b0, a_q, q_q[N-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    a_d     = '0;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: state_d = S_TEST;
            S_TEST: state_d = q_q[0] ? S_ADD : S_SHIFT;
            S_ADD: begin
                a_d     = {1'b0, a_q[N-1:0]} + {1'b0, m_q};
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                a_d   = shifted[2*N:N];
                q_d   = shifted[N-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    product_d = shifted[2*N-1:0];
                    state_d   = S_DONE;
                end else begin
                    state_d = S_TEST;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    assign product = product_q;

endmodule

// File: tb/tb_mult_shift_add.sv
// tb/tb_mult_shift_add.sv - self-checking bench for mult_shift_add at N=4 and N=8
module tb_mult_shift_add;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start4 = 1'b0, start8 = 1'b0;
    logic [3:0]  mc4 = '0, mp4 = '0;
    logic [7:0]  mc8 = '0, mp8 = '0;
    logic [7:0]  product4;
    logic [15:0] product8;
    logic        busy4, done4, busy8, done8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_shift_add #(.N(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .multiplicand(mc4), .multiplier(mp4),
        .product(product4), .busy(busy4), .done(done4)
    );

    mult_shift_add #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8),
        .multiplicand(mc8), .multiplier(mp8),
        .product(product8), .busy(busy8), .done(done8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input bit w8, input logic s, input logic [7:0] m, input logic [7:0] q);
        if (w8) begin
            start8 = s; mc8 = m; mp8 = q;
        end else begin
            start4 = s; mc4 = m[3:0]; mp4 = q[3:0];
        end
    endtask

    function automatic logic [15:0] obs_product(input bit w8);
        return w8 ? product8 : {8'h00, product4};
    endfunction

    function automatic logic obs_busy(input bit w8);
        return w8 ? busy8 : busy4;
    endfunction

    function automatic logic obs_done(input bit w8);
        return w8 ? done8 : done4;
    endfunction

    // Reference: product is plain multiplication; latency is 2N+1 plus one per set multiplier bit.
    task automatic run_op(input bit w8, input logic [7:0] m, input logic [7:0] q, input bit inject,
                          input string tag);
        int n, lat, busy_cnt, done_cnt, done_at, j;
        logic [7:0] mm, qq;
        logic [15:0] exp_p;
        n  = w8 ? 8 : 4;
        mm = w8 ? m : {4'h0, m[3:0]};
        qq = w8 ? q : {4'h0, q[3:0]};
        exp_p = 16'(mm) * 16'(qq);
        lat = 2 * n + 1 + $countones(qq);
        @(negedge clk);
        drive(w8, 1'b1, mm, qq);
        @(posedge clk);
        #1;
        drive(w8, 1'b0, $urandom, $urandom);
        busy_cnt = 0; done_cnt = 0; done_at = -1; j = 0;
        while (j < 200) begin
            if (inject && j == 3) drive(w8, 1'b1, 8'd2, 8'd2);
            if (inject && j == 4) drive(w8, 1'b0, 8'd2, 8'd2);
            if (obs_done(w8)) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
                check({tag, " product"}, 64'(obs_product(w8)), 64'(exp_p));
            end
            if (!obs_busy(w8)) break;
            busy_cnt++;
            @(posedge clk);
            #1;
            j++;
        end
        check({tag, " done_at"}, 64'(done_at), 64'(lat));
        check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(lat + 1));
        repeat (2) @(posedge clk);
        #1;
        check({tag, " product_hold"}, 64'(obs_product(w8)), 64'(exp_p));
        check({tag, " idle_busy"}, 64'(obs_busy(w8)), 64'd0);
    endtask

    initial begin
        int d1, d2, idle_between, j;
        logic [7:0] p1, p2;
        bit seen_idle;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst product4", 64'(product4), 64'd0);
        check("rst product8", 64'(product8), 64'd0);
        check("rst busy", 64'(busy4), 64'd0);
        check("rst done", 64'(done4), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("idle busy", 64'(busy4 | busy8), 64'd0);
        end

        run_op(1'b0, 8'd9, 8'd0, 1'b0, "9x0");
        run_op(1'b0, 8'd15, 8'd15, 1'b0, "15x15");
        run_op(1'b0, 8'd13, 8'd11, 1'b1, "13x11 inject");

        // Abort mid-operation
        @(negedge clk);
        drive(1'b0, 1'b1, 8'd7, 8'd5);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort product", 64'(product4), 64'd0);
        check("abort busy", 64'(busy4), 64'd0);
        check("abort done", 64'(done4), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 8'd3, 8'd6, 1'b0, "3x6 after abort");

        // Back-to-back with start held high
        @(negedge clk);
        drive(1'b0, 1'b1, 8'd6, 8'd7);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 8'd5, 8'd5);
        d1 = -1; d2 = -1; p1 = '0; p2 = '0; idle_between = 0; seen_idle = 1'b0; j = 0;
        while (j < 200 && d2 < 0) begin
            if (done4) begin
                if (d1 < 0) begin d1 = j; p1 = product4; end
                else begin d2 = j; p2 = product4; end
            end
            if (d1 >= 0 && !busy4) begin idle_between++; seen_idle = 1'b1; end
            if (seen_idle && busy4) start4 = 1'b0;
            @(posedge clk);
            #1;
            j++;
        end
        check("b2b first product", 64'(p1), 64'd42);
        check("b2b second product", 64'(p2), 64'd25);
        check("b2b first done_at", 64'(d1), 64'd12);
        check("b2b second done_at", 64'(d2), 64'(12 + 2 + 11));
        check("b2b idle cycles", 64'(idle_between), 64'd1);
        start4 = 1'b0;
        repeat (2) @(posedge clk);

        run_op(1'b1, 8'd255, 8'd255, 1'b0, "255x255");

        for (int i = 0; i < 12; i++) run_op(1'b0, 8'($urandom), 8'($urandom), 1'b0, "rand4");
        for (int i = 0; i < 6; i++)  run_op(1'b1, 8'($urandom), 8'($urandom), 1'b0, "rand8");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
